hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage RV32I core. Sits beside the ID stage, consumes the decoded opcode/rd/rs1/rs2 fields of the ID instruction, and keeps its own shadow copy of the EX/MEM/WB destination state.
- Issues stall, flush and forwarding-select controls to the IF/ID/EX pipeline registers and the EX operand muxes.
- Counts stall cycles for performance monitoring.

Parameters:
- FWD_EN, 1, 1 = EX operand forwarding enabled; 0 = no forwarding, RAW hazards resolved by stalling only.
- CNT_W, 32, width of the stall-cycle counter.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_opcode  in  7  opcode of the ID instruction.
- id_rd  in  5  destination register of the ID instruction.
- id_rs1  in  5  source register 1 of the ID instruction.
- id_rs2  in  5  source register 2 of the ID instruction.
- ex_branch_taken  in  1  EX has resolved a taken branch/jump this cycle.
- ex_busy  in  1  multi-cycle unit in EX is not finished.
- stall_pc  out  1  hold PC.
- stall_id  out  1  hold the IF/ID register.
- stall_ex  out  1  hold the ID/EX register.
- flush_id  out  1  clear the IF/ID register to a bubble.
- flush_ex  out  1  load a bubble into the ID/EX register.
- fwd_a  out  2  EX rs1 source select: 00 regfile, 10 MEM result, 01 WB result.
- fwd_b  out  2  EX rs2 source select, same encoding as fwd_a.
- stall_cycles  out  CNT_W  saturating count of cycles with stall_pc=1.

Behaviour:
- Reset (async on rst_n low):
  - Shadow EX/MEM/WB entries (valid, rd, rs1, rs2, regwrite, memread) cleared; stall_cycles=0.
  - While rst_n=0, all control outputs are forced to 0.
- ID decode (combinational):
  - uses_rs1 = opcode not in {0110111 LUI, 0010111 AUIPC, 1101111 JAL}.
  - uses_rs2 = opcode in {0110011, 0100011, 1100011}.
  - regwrite = opcode in {0110011, 0010011, 0000011, 1101111, 1100111, 0110111, 0010111} and rd!=0.
  - memread = opcode 0000011.
  - Unknown opcodes: uses/regwrite/memread all 0.
- RAW match (for a given stage S): S.valid & S.regwrite & ((uses_rs1 & rs1==S.rd) | (uses_rs2 & rs2==S.rd)). x0 never matches.
- Priority, highest first; all outputs are combinational from inputs plus shadow state (zero latency):
  1. ex_busy=1:
     - stall_pc=stall_id=stall_ex=1; flush_ex=0.
     - ex_branch_taken is ignored.
     - Shadow EX holds; MEM receives a bubble; WB takes MEM.
  2. ex_branch_taken=1 (EX valid):
     - flush_id=1, flush_ex=1, no stalls.
     - Shadow EX takes a bubble; the ID instruction is discarded.
  3. load-use (id_valid & RAW match on EX with EX.memread), or, when FWD_EN=0, id_valid & RAW match on EX or MEM:
     - stall_pc=stall_id=1, flush_ex=1.
     - Shadow EX takes a bubble.
  4. Otherwise: no stall or flush.
     - Shadow EX takes the ID fields, with valid=id_valid.
- Shadow advance: in every non-busy cycle, MEM<=EX and WB<=MEM. The register file writes before it reads, so WB-stage RAW needs neither stall nor forward in ID.
- Forwarding (FWD_EN=1): for EX.rs1 and EX.rs2 independently:
  - 10 if MEM.valid & MEM.regwrite & MEM.rd==src & src!=0;
  - else 01 if the same condition holds on WB;
  - else 00.
  - MEM has priority over WB (newest value).
  - Outputs are 00 when EX is invalid.
- FWD_EN=0: fwd_a=fwd_b=00 always.
- stall_cycles: +1 on each clock edge where stall_pc=1; saturates at all-ones and never wraps.
- Reset mid-stall or mid-busy: all state cleared immediately; no pending stall survives.

Test Plan:
- Reset: assert rst_n=0 with id_valid=1, ex_busy=1 -> all outputs 0, stall_cycles=0; release -> stall_pc=0 with an empty pipe.
- Load-use: lw x5 (opcode 0000011, rd=5), then ID add x6,x5,x7 (0110011, rs1=5) -> stall_pc=stall_id=flush_ex=1 for exactly 1 cycle; next cycle fwd_a=01 (WB); stall_cycles=1.
- Forward priority: addi x3 then addi x3 back-to-back, then ID add rs1=3 rs2=3 -> when that add is in EX, fwd_a=fwd_b=10 (MEM wins over WB).
- x0 and non-users: lw x0, then add rs1=0 -> no stall. lw x5, then lui x5 (no rs) -> no stall.
- Branch vs load-use: ex_branch_taken=1 in the same cycle as a load-use match -> flush_id=flush_ex=1, stall_pc=0. Busy: ex_busy=1 together with branch_taken=1 -> stalls only, no flush.
- FWD_EN=0: addi x4 then add rs2=4 -> 2 stall cycles (EX match, then MEM match), fwd_b=00 throughout. Preload stall_cycles to all-ones (CNT_W=4 build: 15) plus one more stall -> stays 15.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencing controller for a 5-stage RV32I core.
// It decodes the ID-stage instruction and keeps a shadow copy of the
// EX/MEM/WB destination state. From these it produces the stall, flush and
// forwarding-select controls, and it counts stall cycles (saturating).
//
// Ports:
//   clk, rst_n                  core clock (rising edge), async active-low reset
//   id_valid                    ID stage holds a real instruction
//   id_opcode/rd/rs1/rs2        decoded fields of the ID instruction
//   ex_branch_taken             EX resolved a taken branch/jump this cycle
//   ex_busy                     multi-cycle unit in EX not finished
//   stall_pc/stall_id/stall_ex  hold PC, IF/ID register and ID/EX register
//   flush_id/flush_ex           bubble into IF/ID and ID/EX registers
//   fwd_a/fwd_b                 EX operand select: 00 regfile, 10 MEM, 01 WB
//   stall_cycles                saturating count of cycles with stall_pc=1
module hazard_ctrl #(
    parameter int FWD_EN = 1,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [6:0]       id_opcode,
    input  logic [4:0]       id_rd,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             ex_branch_taken,
    input  logic             ex_busy,
    output logic             stall_pc,
    output logic             stall_id,
    output logic             stall_ex,
    output logic             flush_id,
    output logic             flush_ex,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam logic FWD = (FWD_EN != 0);

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       regwrite;
        logic       memread;
    } stage_t;

    stage_t id_s, ex_q, mem_q, wb_q;
    logic   uses_rs1, uses_rs2;
    logic   load_use, raw_stall, hazard;
    logic [CNT_W-1:0] cnt_q;

    // Only the base RV32I opcodes listed below are recognised; anything else
    // decodes as using no sources and writing nothing.
    always_comb begin
        uses_rs1      = 1'b0;
        uses_rs2      = 1'b0;
        id_s.regwrite = 1'b0;
        id_s.memread  = 1'b0;
        case (id_opcode)
            7'b0110011: begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; id_s.regwrite = 1'b1; end
            7'b0010011: begin uses_rs1 = 1'b1; id_s.regwrite = 1'b1; end
            7'b0000011: begin uses_rs1 = 1'b1; id_s.regwrite = 1'b1; id_s.memread = 1'b1; end
            7'b0100011: begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
            7'b1100011: begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
            7'b1100111: begin uses_rs1 = 1'b1; id_s.regwrite = 1'b1; end
            7'b1101111: id_s.regwrite = 1'b1;
            7'b0110111: id_s.regwrite = 1'b1;
            7'b0010111: id_s.regwrite = 1'b1;
            default:    ;
        endcase
        // Writes to x0 are discarded, which also keeps x0 out of every match.
        if (id_rd == 5'd0) id_s.regwrite = 1'b0;
        id_s.valid = id_valid;
        id_s.rd    = id_rd;
        id_s.rs1   = id_rs1;
        id_s.rs2   = id_rs2;
    end

    function automatic logic raw_match(input stage_t s, input logic u1, input logic u2,
                                       input logic [4:0] r1, input logic [4:0] r2);
        return s.valid & s.regwrite & ((u1 & (r1 == s.rd)) | (u2 & (r2 == s.rd)));
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [4:0] src, input stage_t m, input stage_t w);
        if (m.valid && m.regwrite && m.rd == src && src != 5'd0) return 2'b10;
        if (w.valid && w.regwrite && w.rd == src && src != 5'd0) return 2'b01;
        return 2'b00;
    endfunction

    always_comb begin
        load_use  = id_valid & ex_q.memread & raw_match(ex_q, uses_rs1, uses_rs2, id_rs1, id_rs2);
        raw_stall = !FWD & id_valid & (raw_match(ex_q, uses_rs1, uses_rs2, id_rs1, id_rs2) |
                                       raw_match(mem_q, uses_rs1, uses_rs2, id_rs1, id_rs2));
        hazard    = load_use | raw_stall;
    end

    always_comb begin
        stall_pc = 1'b0;
        stall_id = 1'b0;
        stall_ex = 1'b0;
        flush_id = 1'b0;
        flush_ex = 1'b0;
        fwd_a    = 2'b00;
        fwd_b    = 2'b00;
        if (rst_n) begin
            if (ex_busy) begin
                stall_pc = 1'b1;
                stall_id = 1'b1;
                stall_ex = 1'b1;
            end else if (ex_branch_taken) begin
                flush_id = 1'b1;
                flush_ex = 1'b1;
            end else if (hazard) begin
                stall_pc = 1'b1;
                stall_id = 1'b1;
                flush_ex = 1'b1;
            end
            if (FWD && ex_q.valid) begin
                fwd_a = fwd_sel(ex_q.rs1, mem_q, wb_q);
                fwd_b = fwd_sel(ex_q.rs2, mem_q, wb_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
            cnt_q <= '0;
        end else begin
            wb_q <= mem_q;
            if (ex_busy) begin
                mem_q <= '0;
            end else begin
                mem_q <= ex_q;
                if (ex_branch_taken || hazard) ex_q <= '0;
                else                           ex_q <= id_s;
            end
            if (stall_pc && cnt_q != {CNT_W{1'b1}})
                cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign stall_cycles = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_ADD  = 7'b0110011;
    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_NOP  = 7'b0000000;

    // expected control vector {stall_pc,stall_id,stall_ex,flush_id,flush_ex,fwd_a,fwd_b}
    localparam logic [8:0] C_IDLE = 9'b000_00_0000;
    localparam logic [8:0] C_LU   = 9'b110_01_0000;
    localparam logic [8:0] C_BR   = 9'b000_11_0000;
    localparam logic [8:0] C_BUSY = 9'b111_00_0000;

    typedef struct packed {
        logic       v;
        logic [6:0] op;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       br;
        logic       busy;
        logic [8:0] exp;
    } step_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, ex_branch_taken, ex_busy;
    logic [6:0]  id_opcode;
    logic [4:0]  id_rd, id_rs1, id_rs2;

    logic        s_pc, s_id, s_ex, f_id, f_ex;
    logic [1:0]  fa, fb;
    logic [31:0] cnt;
    logic        s_pc0, s_id0, s_ex0, f_id0, f_ex0;
    logic [1:0]  fa0, fb0;
    logic [3:0]  cnt0;
    logic [8:0]  ctl, ctl0;

    int n_pass = 0;
    int n_total = 0;
    logic [8:0] sbq[$];

    always #5 clk = ~clk;

    hazard_ctrl #(.FWD_EN(1), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .ex_branch_taken(ex_branch_taken), .ex_busy(ex_busy),
        .stall_pc(s_pc), .stall_id(s_id), .stall_ex(s_ex),
        .flush_id(f_id), .flush_ex(f_ex), .fwd_a(fa), .fwd_b(fb),
        .stall_cycles(cnt)
    );

    hazard_ctrl #(.FWD_EN(0), .CNT_W(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .ex_branch_taken(ex_branch_taken), .ex_busy(ex_busy),
        .stall_pc(s_pc0), .stall_id(s_id0), .stall_ex(s_ex0),
        .flush_id(f_id0), .flush_ex(f_ex0), .fwd_a(fa0), .fwd_b(fb0),
        .stall_cycles(cnt0)
    );

    assign ctl  = {s_pc, s_id, s_ex, f_id, f_ex, fa, fb};
    assign ctl0 = {s_pc0, s_id0, s_ex0, f_id0, f_ex0, fa0, fb0};

    function automatic step_t mk(input logic v, input logic [6:0] op, input logic [4:0] rd,
                                 input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic br, input logic busy, input logic [8:0] exp);
        step_t s;
        s.v = v; s.op = op; s.rd = rd; s.rs1 = rs1; s.rs2 = rs2;
        s.br = br; s.busy = busy; s.exp = exp;
        return s;
    endfunction

    // Drives one cycle of stimulus just after the rising edge and records the
    // control vector the bench expects for it.
    task automatic drive(input step_t s);
        @(posedge clk);
        #1;
        id_valid        = s.v;
        id_opcode       = s.op;
        id_rd           = s.rd;
        id_rs1          = s.rs1;
        id_rs2          = s.rs2;
        ex_branch_taken = s.br;
        ex_busy         = s.busy;
        sbq.push_back(s.exp);
    endtask

    task automatic idle_inputs();
        id_valid = 1'b0; id_opcode = OP_NOP; id_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0;
        ex_branch_taken = 1'b0; ex_busy = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        idle_inputs();
        sbq.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        id_valid = 1'b1; ex_busy = 1'b1; ex_branch_taken = 1'b1;
        id_opcode = OP_ADD; id_rd = 5'd1; id_rs1 = 5'd1; id_rs2 = 5'd1;
        repeat (2) @(negedge clk);
        n_total++;
        if (ctl !== C_IDLE || ctl0 !== C_IDLE) $display("FAIL reset_ctl: got %b/%b want %b", ctl, ctl0, C_IDLE);
        else n_pass++;
        n_total++;
        if (cnt !== 32'd0 || cnt0 !== 4'd0) $display("FAIL reset_cnt: got %0d/%0d want 0", cnt, cnt0);
        else n_pass++;
        @(posedge clk);
        #1;
        idle_inputs();
        rst_n = 1'b1;
        @(negedge clk);
        n_total++;
        if (ctl !== C_IDLE || ctl0 !== C_IDLE) $display("FAIL reset_release: got %b/%b want %b", ctl, ctl0, C_IDLE);
        else n_pass++;
    endtask

    task automatic test_load_use();
        step_t st[$];
        logic [8:0] e;
        do_reset();
        st.push_back(mk(1, OP_LW,  5, 0, 0, 0, 0, C_IDLE));
        st.push_back(mk(1, OP_ADD, 6, 5, 7, 0, 0, C_LU));
        st.push_back(mk(1, OP_ADD, 6, 5, 7, 0, 0, C_IDLE));
        st.push_back(mk(0, OP_NOP, 0, 0, 0, 0, 0, 9'b000_00_0100));
        foreach (st[i]) begin
            drive(st[i]);
            @(negedge clk);
            e = sbq.pop_front();
            n_total++;
            if (ctl !== e) $display("FAIL load_use[%0d]: got %b want %b", i, ctl, e);
            else n_pass++;
        end
        n_total++;
        if (cnt !== 32'd1) $display("FAIL load_use_cnt: got %0d want 1", cnt);
        else n_pass++;
    endtask

    task automatic test_fwd_priority();
        step_t st[$];
        logic [8:0] e;
        do_reset();
        st.push_back(mk(1, OP_ADDI, 3, 0, 0, 0, 0, C_IDLE));
        st.push_back(mk(1, OP_ADDI, 3, 0, 0, 0, 0, C_IDLE));
        st.push_back(mk(1, OP_ADD,  8, 3, 3, 0, 0, C_IDLE));
        st.push_back(mk(0, OP_NOP,  0, 0, 0, 0, 0, 9'b000_00_1010));
        st.push_back(mk(0, OP_NOP,  0, 0, 0, 0, 0, C_IDLE));
        foreach (st[i]) begin
            drive(st[i]);
            @(negedge clk);
            e = sbq.pop_front();
            n_total++;
            if (ctl !== e) $display("FAIL fwd_priority[%0d]: got %b want %b", i, ctl, e);
            else n_pass++;
        end
    endtask

    task automatic test_x0_nonuser();
        step_t st[$];
        logic [8:0] e;
        do_reset();
        st.push_back(mk(1, OP_LW,  0, 0, 0, 0, 0, C_IDLE));
        st.push_back(mk(1, OP_ADD, 6, 0, 0, 0, 0, C_IDLE));
        foreach (st[i]) begin
            drive(st[i]);
            @(negedge clk);
            e = sbq.pop_front();
            n_total++;
            if (ctl !== e) $display("FAIL x0_no_stall[%0d]: got %b want %b", i, ctl, e);
            else n_pass++;
        end
        do_reset();
        st.delete();
        st.push_back(mk(1, OP_LW,  5, 0, 0, 0, 0, C_IDLE));
        st.push_back(mk(1, OP_LUI, 5, 5, 5, 0, 0, C_IDLE));
        foreach (st[i]) begin
            drive(st[i]);
            @(negedge clk);
            e = sbq.pop_front();
            n_total++;
            if (ctl !== e) $display("FAIL lui_no_stall[%0d]: got %b want %b", i, ctl, e);
            else n_pass++;
        end
    endtask

    task automatic test_branch_busy();
        step_t st[$];
        logic [8:0] e;
        do_reset();
        st.push_back(mk(1, OP_LW,  5, 0, 0, 0, 0, C_IDLE));
        st.push_back(mk(1, OP_ADD, 6, 5, 7, 1, 0, C_BR));
        st.push_back(mk(0, OP_NOP, 0, 0, 0, 0, 0, C_IDLE));
        st.push_back(mk(1, OP_ADD, 6, 5, 7, 1, 1, C_BUSY));
        st.push_back(mk(0, OP_NOP, 0, 0, 0, 0, 0, C_IDLE));
        foreach (st[i]) begin
            drive(st[i]);
            @(negedge clk);
            e = sbq.pop_front();
            n_total++;
            if (ctl !== e) $display("FAIL branch_busy[%0d]: got %b want %b", i, ctl, e);
            else n_pass++;
        end
        n_total++;
        if (cnt !== 32'd1) $display("FAIL branch_busy_cnt: got %0d want 1", cnt);
        else n_pass++;
    endtask

    task automatic test_busy_hold();
        step_t st[$];
        logic [8:0] e;
        do_reset();
        st.push_back(mk(1, OP_ADDI, 3, 0, 0, 0, 0, C_IDLE));
        st.push_back(mk(1, OP_ADD,  8, 3, 0, 0, 1, C_BUSY));
        st.push_back(mk(1, OP_ADD,  8, 3, 0, 0, 1, C_BUSY));
        st.push_back(mk(1, OP_ADD,  8, 3, 0, 0, 0, C_IDLE));
        st.push_back(mk(0, OP_NOP,  0, 0, 0, 0, 0, 9'b000_00_1000));
        foreach (st[i]) begin
            drive(st[i]);
            @(negedge clk);
            e = sbq.pop_front();
            n_total++;
            if (ctl !== e) $display("FAIL busy_hold[%0d]: got %b want %b", i, ctl, e);
            else n_pass++;
        end
        n_total++;
        if (cnt !== 32'd2) $display("FAIL busy_hold_cnt: got %0d want 2", cnt);
        else n_pass++;
    endtask

    task automatic test_no_fwd();
        step_t st[$];
        logic [8:0] e;
        do_reset();
        st.push_back(mk(1, OP_ADDI, 4, 0, 0, 0, 0, C_IDLE));
        st.push_back(mk(1, OP_ADD,  9, 0, 4, 0, 0, C_LU));
        st.push_back(mk(1, OP_ADD,  9, 0, 4, 0, 0, C_LU));
        st.push_back(mk(1, OP_ADD,  9, 0, 4, 0, 0, C_IDLE));
        st.push_back(mk(0, OP_NOP,  0, 0, 0, 0, 0, C_IDLE));
        foreach (st[i]) begin
            drive(st[i]);
            @(negedge clk);
            e = sbq.pop_front();
            n_total++;
            if (ctl0 !== e) $display("FAIL no_fwd[%0d]: got %b want %b", i, ctl0, e);
            else n_pass++;
        end
        n_total++;
        if (cnt0 !== 4'd2) $display("FAIL no_fwd_cnt: got %0d want 2", cnt0);
        else n_pass++;
    endtask

    task automatic test_saturation();
        logic [8:0] e;
        do_reset();
        for (int i = 0; i < 15; i++) begin
            drive(mk(0, OP_NOP, 0, 0, 0, 0, 1, C_BUSY));
            @(negedge clk);
            e = sbq.pop_front();
            n_total++;
            if (ctl0 !== e) $display("FAIL sat_busy[%0d]: got %b want %b", i, ctl0, e);
            else n_pass++;
        end
        drive(mk(0, OP_NOP, 0, 0, 0, 0, 0, C_IDLE));
        @(negedge clk);
        e = sbq.pop_front();
        n_total++;
        if (cnt0 !== 4'd15 || ctl0 !== e) $display("FAIL sat_full: got %0d/%b want 15/%b", cnt0, ctl0, e);
        else n_pass++;
        drive(mk(0, OP_NOP, 0, 0, 0, 0, 1, C_BUSY));
        @(negedge clk);
        e = sbq.pop_front();
        n_total++;
        if (ctl0 !== e) $display("FAIL sat_extra: got %b want %b", ctl0, e);
        else n_pass++;
        drive(mk(0, OP_NOP, 0, 0, 0, 0, 0, C_IDLE));
        @(negedge clk);
        e = sbq.pop_front();
        n_total++;
        if (cnt0 !== 4'd15 || ctl0 !== e) $display("FAIL sat_hold: got %0d/%b want 15/%b", cnt0, ctl0, e);
        else n_pass++;
        // asynchronous reset in the middle of a busy stall
        drive(mk(1, OP_ADD, 6, 5, 7, 0, 1, C_BUSY));
        @(negedge clk);
        e = sbq.pop_front();
        n_total++;
        if (ctl0 !== e) $display("FAIL midbusy_pre: got %b want %b", ctl0, e);
        else n_pass++;
        #1;
        rst_n = 1'b0;
        #1;
        n_total++;
        if (ctl0 !== C_IDLE || ctl !== C_IDLE || cnt0 !== 4'd0 || cnt !== 32'd0)
            $display("FAIL midbusy_reset: got %b/%b cnt %0d/%0d want %b cnt 0", ctl, ctl0, cnt, cnt0, C_IDLE);
        else n_pass++;
        @(posedge clk);
        #1;
        idle_inputs();
        rst_n = 1'b1;
        @(negedge clk);
        n_total++;
        if (ctl0 !== C_IDLE || cnt0 !== 4'd0) $display("FAIL midbusy_after: got %b cnt %0d want %b cnt 0", ctl0, cnt0, C_IDLE);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_fwd_priority();
        test_x0_nonuser();
        test_branch_busy();
        test_busy_hold();
        test_no_fwd();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
